// File: rtl/shift_decoder.sv
// Tracks a one-hot rotating pattern from an upstream shift counter and reports
// the hot-bit position, completed wraps (laps) and sticky sequence faults.
module shift_decoder #(
    parameter int unsigned LAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [7:0]       count_in,
    input  logic             clr_err,
    output logic [2:0]       pos,
    output logic             valid,
    output logic [LAP_W-1:0] lap,
    output logic             lap_tick,
    output logic             err,
    output logic [3:0]       err_cnt,
    output logic [1:0]       state
);

    localparam int unsigned PAT_W   = 8;
    localparam int unsigned POS_W   = 3;
    localparam int unsigned ECNT_W  = 4;
    localparam logic [PAT_W-1:0]  PAT_FIRST = PAT_W'(8'h01);
    localparam logic [PAT_W-1:0]  PAT_LAST  = PAT_W'(8'h80);
    localparam logic [ECNT_W-1:0] ECNT_MAX  = ECNT_W'(4'hF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    state_e             state_q,    state_d;
    logic [PAT_W-1:0]   prev_q,     prev_d;
    logic [POS_W-1:0]   pos_q,      pos_d;
    logic               valid_q,    valid_d;
    logic [LAP_W-1:0]   lap_q,      lap_d;
    logic               lap_tick_q, lap_tick_d;
    logic               err_q,      err_d;
    logic [ECNT_W-1:0]  err_cnt_q,  err_cnt_d;

    logic [PAT_W-1:0]   expected_c;

    // OR-tree encoder; only meaningful for patterns already known to be one-hot
    function automatic logic [POS_W-1:0] onehot_to_bin(input logic [PAT_W-1:0] p);
        logic [POS_W-1:0] b;
        b[0] = p[1] | p[3] | p[5] | p[7];
        b[1] = p[2] | p[3] | p[6] | p[7];
        b[2] = p[4] | p[5] | p[6] | p[7];
        return b;
    endfunction

    assign expected_c = {prev_q[PAT_W-2:0], prev_q[PAT_W-1]};

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        pos_d      = pos_q;
        valid_d    = valid_q;
        lap_d      = lap_q;
        lap_tick_d = 1'b0;
        err_d      = err_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (en && (count_in == PAT_FIRST)) begin
                    state_d = ST_TRACK;
                    prev_d  = PAT_FIRST;
                    pos_d   = POS_W'(0);
                    valid_d = 1'b1;
                end
            end

            ST_TRACK: begin
                if (en) begin
                    if (count_in == expected_c) begin
                        prev_d  = count_in;
                        pos_d   = onehot_to_bin(count_in);
                        valid_d = 1'b1;
                        if (prev_q == PAT_LAST) begin
                            lap_d      = lap_q + LAP_W'(1);
                            lap_tick_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_FAULT;
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        if (err_cnt_q != ECNT_MAX) begin
                            err_cnt_d = err_cnt_q + ECNT_W'(1);
                        end
                    end
                end
            end

            ST_FAULT: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                // clr_err wins over en; the sample on this edge is dropped
                if (clr_err) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            prev_q     <= '0;
            pos_q      <= '0;
            valid_q    <= 1'b0;
            lap_q      <= '0;
            lap_tick_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pos_q      <= pos_d;
            valid_q    <= valid_d;
            lap_q      <= lap_d;
            lap_tick_q <= lap_tick_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign state    = state_q;
    assign pos      = pos_q;
    assign valid    = valid_q;
    assign lap      = lap_q;
    assign lap_tick = lap_tick_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_shift_decoder.sv
// Bench for shift_decoder: directed vector table, corner sequences and random
// stimulus checked against an index-based reference model.
module tb_shift_decoder;

    localparam int LAP_W = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic [7:0]       count_in;
    logic             clr_err;
    logic [2:0]       pos;
    logic             valid;
    logic [LAP_W-1:0] lap;
    logic             lap_tick;
    logic             err;
    logic [3:0]       err_cnt;
    logic [1:0]       state;

    int total = 0;
    int bad   = 0;

    shift_decoder #(.LAP_W(LAP_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .count_in (count_in),
        .clr_err  (clr_err),
        .pos      (pos),
        .valid    (valid),
        .lap      (lap),
        .lap_tick (lap_tick),
        .err      (err),
        .err_cnt  (err_cnt),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=track 2=fault, idx = position of last accepted bit
    int m_mode, m_idx, m_valid, m_lap, m_tick, m_err, m_ecnt;

    function automatic void model_reset();
        m_mode = 0; m_idx = 0; m_valid = 0; m_lap = 0; m_tick = 0; m_err = 0; m_ecnt = 0;
    endfunction

    function automatic void model_step(input logic e, input logic [7:0] c, input logic cl);
        int nxt;
        m_tick = 0;
        if (m_mode == 2) begin
            if (cl) begin
                m_mode = 0;
                m_err  = 0;
            end
        end else if (e) begin
            if (m_mode == 0) begin
                if (c == 8'h01) begin
                    m_mode = 1; m_idx = 0; m_valid = 1;
                end
            end else begin
                nxt = (m_idx + 1) % 8;
                if (int'(c) == (1 << nxt)) begin
                    if (m_idx == 7) begin
                        m_lap  = (m_lap + 1) % (1 << LAP_W);
                        m_tick = 1;
                    end
                    m_idx = nxt;
                end else begin
                    m_mode  = 2;
                    m_err   = 1;
                    m_valid = 0;
                    if (m_ecnt < 15) m_ecnt = m_ecnt + 1;
                end
            end
        end
    endfunction

    function automatic logic [7:0] good_pattern();
        if (m_mode == 1) return 8'(1 << ((m_idx + 1) % 8));
        return 8'h01;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_all();
        check("state",    32'(state),    32'(m_mode));
        check("pos",      32'(pos),      32'(m_idx));
        check("valid",    32'(valid),    32'(m_valid));
        check("lap",      32'(lap),      32'(m_lap));
        check("lap_tick", 32'(lap_tick), 32'(m_tick));
        check("err",      32'(err),      32'(m_err));
        check("err_cnt",  32'(err_cnt),  32'(m_ecnt));
    endfunction

    task automatic cycle(input logic e, input logic [7:0] c, input logic cl);
        en = e; count_in = c; clr_err = cl;
        @(posedge clk);
        model_step(e, c, cl);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic [7:0] cin;
        logic       clr;
        int         st, p, v, t, l, e, ec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic [7:0] c, input logic cl,
                                input int st, input int p, input int v, input int t,
                                input int l, input int er, input int ec);
        vec_t x;
        x.en = e; x.cin = c; x.clr = cl;
        x.st = st; x.p = p; x.v = v; x.t = t; x.l = l; x.e = er; x.ec = ec;
        vecs.push_back(x);
    endfunction

    int ticks;
    int lap_before;

    initial begin
        reset = 1'b0; en = 1'b0; count_in = 8'h00; clr_err = 1'b0;
        model_reset();
        #2;
        check("reset_state",   32'(state),   32'd0);
        check("reset_valid",   32'(valid),   32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //  en   cin    clr  st pos v tick lap err ecnt
        add(1, 8'h01, 0,  1, 0, 1, 0, 0, 0, 0);
        add(1, 8'h02, 0,  1, 1, 1, 0, 0, 0, 0);
        add(1, 8'h04, 0,  1, 2, 1, 0, 0, 0, 0);
        add(1, 8'h10, 0,  2, 2, 0, 0, 0, 1, 1);  // skipped bit
        add(1, 8'h01, 0,  2, 2, 0, 0, 0, 1, 1);  // ignored in fault
        add(1, 8'h08, 1,  0, 2, 0, 0, 0, 0, 1);  // clear, sample dropped
        add(1, 8'h00, 0,  0, 2, 0, 0, 0, 0, 1);
        add(1, 8'h01, 0,  1, 0, 1, 0, 0, 0, 1);
        add(1, 8'h02, 0,  1, 1, 1, 0, 0, 0, 1);
        add(1, 8'h04, 0,  1, 2, 1, 0, 0, 0, 1);
        add(1, 8'h08, 0,  1, 3, 1, 0, 0, 0, 1);
        add(1, 8'h10, 0,  1, 4, 1, 0, 0, 0, 1);
        add(1, 8'h20, 0,  1, 5, 1, 0, 0, 0, 1);
        add(1, 8'h40, 0,  1, 6, 1, 0, 0, 0, 1);
        add(1, 8'h80, 0,  1, 7, 1, 0, 0, 0, 1);
        add(1, 8'h01, 0,  1, 0, 1, 1, 1, 0, 1);  // wrap -> lap tick
        add(1, 8'h02, 0,  1, 1, 1, 0, 1, 0, 1);
        add(0, 8'h08, 0,  1, 1, 1, 0, 1, 0, 1);  // en low holds
        add(1, 8'h04, 1,  1, 2, 1, 0, 1, 0, 1);  // clr in track no effect
        add(1, 8'h08, 0,  1, 3, 1, 0, 1, 0, 1);
        add(1, 8'h01, 0,  2, 3, 0, 0, 1, 1, 2);  // upstream restart is a fault
        add(0, 8'h00, 1,  0, 3, 0, 0, 1, 0, 2);  // clear with en low
        add(1, 8'h01, 0,  1, 0, 1, 0, 1, 0, 2);
        add(1, 8'h01, 0,  2, 0, 0, 0, 1, 1, 3);  // held pattern
        add(1, 8'h01, 1,  0, 0, 0, 0, 1, 0, 3);
        add(1, 8'h03, 0,  0, 0, 0, 0, 1, 0, 3);  // idle ignores junk
        add(1, 8'h01, 0,  1, 0, 1, 0, 1, 0, 3);
        add(1, 8'h03, 0,  2, 0, 0, 0, 1, 1, 4);  // multi-hot

        foreach (vecs[i]) begin
            en = vecs[i].en; count_in = vecs[i].cin; clr_err = vecs[i].clr;
            @(posedge clk);
            model_step(vecs[i].en, vecs[i].cin, vecs[i].clr);
            #1;
            check($sformatf("vec%0d_state", i), 32'(state),    32'(vecs[i].st));
            check($sformatf("vec%0d_pos", i),   32'(pos),      32'(vecs[i].p));
            check($sformatf("vec%0d_valid", i), 32'(valid),    32'(vecs[i].v));
            check($sformatf("vec%0d_tick", i),  32'(lap_tick), 32'(vecs[i].t));
            check($sformatf("vec%0d_lap", i),   32'(lap),      32'(vecs[i].l));
            check($sformatf("vec%0d_err", i),   32'(err),      32'(vecs[i].e));
            check($sformatf("vec%0d_ecnt", i),  32'(err_cnt),  32'(vecs[i].ec));
        end

        // Frozen while en=0, then resume at the correct next pattern
        do_reset();
        cycle(1, 8'h01, 0);
        cycle(1, 8'h02, 0);
        cycle(1, 8'h04, 0);
        for (int k = 0; k < 5; k++) cycle(0, 8'(8'h08 << k), 0);
        cycle(1, 8'h08, 0);
        check("resume_err", 32'(err), 32'd0);
        check("resume_pos", 32'(pos), 32'd3);

        // err_cnt saturation
        do_reset();
        for (int k = 0; k < 16; k++) begin
            cycle(1, 8'h01, 0);
            cycle(1, 8'h01, 0);
            cycle(0, 8'h00, 1);
        end
        check("ecnt_sat", 32'(err_cnt), 32'd15);

        // 256 laps wrap the counter back to where it started
        do_reset();
        cycle(1, 8'h01, 0);
        lap_before = int'(lap);
        ticks = 0;
        for (int l = 0; l < 256; l++) begin
            for (int b = 1; b <= 8; b++) begin
                cycle(1, 8'(1 << (b % 8)), 0);
                if (lap_tick) ticks++;
            end
        end
        check("lap_ticks", 32'(ticks), 32'd256);
        check("lap_wrap",  32'(lap),   32'(lap_before));

        // Async reset between edges while in fault
        cycle(1, 8'h01, 0);
        check("pre_reset_fault", 32'(state), 32'd2);
        #3;
        reset = 1'b0;
        #1;
        check("async_state",   32'(state),    32'd0);
        check("async_err",     32'(err),      32'd0);
        check("async_err_cnt", 32'(err_cnt),  32'd0);
        check("async_lap",     32'(lap),      32'd0);
        check("async_valid",   32'(valid),    32'd0);
        check("async_pos",     32'(pos),      32'd0);
        check("async_tick",    32'(lap_tick), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1, 8'h01, 0);
        check("release_edge_track", 32'(state), 32'd1);

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            logic       e, cl;
            logic [7:0] c;
            int         r;
            if ($urandom_range(0, 799) == 0) do_reset();
            e  = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 24) == 0);
            r  = int'($urandom_range(0, 99));
            if (r < 85)      c = good_pattern();
            else if (r < 93) c = 8'($urandom);
            else             c = 8'(1 << $urandom_range(0, 7));
            cycle(e, c, cl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
